// File: rtl/stream_transfer_ctrl.sv
// stream_transfer_ctrl
//   Bridges an SPI byte stream to a multi-channel frame BRAM and starts the
//   image-processing block. The first byte of a frame is a command:
//   opcode in the top two bits, channel in the bottom two.
//     00 NOP      clears the error and done flags
//     01 WRITE    the next PIXELS bytes are written to the selected channel
//     10 READ     PIXELS words of the selected channel are returned over SPI
//     11 PROCESS  pdi_active is held until pdi_done comes back
//   While idle, spi_byte_out carries status {0.., busy, done_flag, err}.
//   Raising ss during a WRITE or READ aborts it and sets err.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   ss                  SPI chip select (active-low)
//   spi_cycle_done      one-cycle pulse per received byte
//   spi_byte_in         received byte
//   spi_byte_out        byte to shift out on the next SPI transfer
//   bram_addr           BRAM word address (always the word counter)
//   bram_channel        selected BRAM channel
//   bram_we             BRAM write strobe
//   bram_data_in        BRAM write data
//   bram_data_out       BRAM read data (one-cycle registered latency)
//   pdi_active          image-processing enable
//   pdi_done            image-processing complete
//   busy                high whenever a command is in progress
module stream_transfer_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 17,
   parameter int NUM_CH = 3,
   parameter int PIXELS = 76800
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss,
   input  logic              spi_cycle_done,
   input  logic [DATA_W-1:0] spi_byte_in,
   output logic [DATA_W-1:0] spi_byte_out,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [1:0]        bram_channel,
   output logic              bram_we,
   output logic [DATA_W-1:0] bram_data_in,
   input  logic [DATA_W-1:0] bram_data_out,
   output logic              pdi_active,
   input  logic              pdi_done,
   output logic              busy
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_PRE, S_RD, S_PDI} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
   localparam logic [2:0]        NUM_CH_W  = 3'(NUM_CH);
   localparam logic [1:0]        OP_NOP    = 2'b00;
   localparam logic [1:0]        OP_WR     = 2'b01;
   localparam logic [1:0]        OP_RD     = 2'b10;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   cnt, cnt_nxt;
   logic [1:0]          chan, chan_nxt;
   logic                err, err_nxt;
   logic                done_flag, done_nxt;
   logic                pdi_nxt;
   logic                load_p1, load_nxt;
   logic [DATA_W-1:0]   sbo_nxt;
   logic                ss_p1, ss_rise;
   logic [1:0]          cmd_op, cmd_ch;
   logic                cmd_ch_bad;
   logic [DATA_W-1:0]   status;

   assign cmd_op       = spi_byte_in[DATA_W-1 -: 2];
   assign cmd_ch       = spi_byte_in[1:0];
   assign cmd_ch_bad   = {1'b0, cmd_ch} >= NUM_CH_W;
   assign ss_rise      = ss & ~ss_p1;
   assign busy         = (state != S_IDLE);
   assign bram_addr    = cnt;
   assign bram_channel = chan;
   assign status       = {{(DATA_W-3){1'b0}}, busy, done_flag, err};

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      chan_nxt     = chan;
      err_nxt      = err;
      done_nxt     = done_flag;
      pdi_nxt      = 1'b0;
      load_nxt     = 1'b0;
      sbo_nxt      = spi_byte_out;
      bram_we      = 1'b0;
      bram_data_in = '0;
      case (state)
         S_IDLE: begin
            sbo_nxt = status;
            if (spi_cycle_done) begin
               if (cmd_op == OP_NOP) begin
                  err_nxt  = 1'b0;
                  done_nxt = 1'b0;
               end else if (cmd_ch_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  chan_nxt = cmd_ch;
                  cnt_nxt  = '0;
                  case (cmd_op)
                     OP_WR:   state_nxt = S_WR;
                     OP_RD:   state_nxt = S_RD_PRE;
                     default: state_nxt = S_PDI;
                  endcase
               end
            end
         end
         S_WR: begin
            // A byte arriving together with the ss edge is still written
            // before the abort takes effect.
            if (spi_cycle_done) begin
               bram_we      = 1'b1;
               bram_data_in = spi_byte_in;
               if (cnt == LAST_ADDR) state_nxt = S_IDLE;
               else                  cnt_nxt   = cnt + 1'b1;
            end
            if (ss_rise) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end
         end
         S_RD_PRE: begin
            // Address is presented this cycle; the BRAM word is valid in the
            // first RD cycle, where it is captured into spi_byte_out.
            state_nxt = S_RD;
            load_nxt  = 1'b1;
            if (ss_rise) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
               load_nxt  = 1'b0;
            end
         end
         S_RD: begin
            if (load_p1) sbo_nxt = bram_data_out;
            if (ss_rise) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end else if (spi_cycle_done) begin
               if (cnt == LAST_ADDR) begin
                  state_nxt = S_IDLE;
               end else begin
                  cnt_nxt   = cnt + 1'b1;
                  state_nxt = S_RD_PRE;
               end
            end
         end
         S_PDI: begin
            // pdi_done only counts once pdi_active has been seen high.
            pdi_nxt = 1'b1;
            if (pdi_active && pdi_done) begin
               pdi_nxt   = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---- state / control register stage ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         chan         <= '0;
         err          <= 1'b0;
         done_flag    <= 1'b0;
         pdi_active   <= 1'b0;
         load_p1      <= 1'b0;
         spi_byte_out <= '0;
         ss_p1        <= 1'b1;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         chan         <= chan_nxt;
         err          <= err_nxt;
         done_flag    <= done_nxt;
         pdi_active   <= pdi_nxt;
         load_p1      <= load_nxt;
         spi_byte_out <= sbo_nxt;
         ss_p1        <= ss;
      end
   end

endmodule

// File: tb/tb_stream_transfer_ctrl.sv
module tb_stream_transfer_ctrl;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int NUM_CH = 3;
   localparam int PIXELS = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              ss = 1'b1;
   logic              spi_cycle_done = 1'b0;
   logic [DATA_W-1:0] spi_byte_in = '0;
   logic [DATA_W-1:0] spi_byte_out;
   logic [ADDR_W-1:0] bram_addr;
   logic [1:0]        bram_channel;
   logic              bram_we;
   logic [DATA_W-1:0] bram_data_in;
   logic [DATA_W-1:0] bram_data_out;
   logic              pdi_active;
   logic              pdi_done = 1'b0;
   logic              busy;

   stream_transfer_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .PIXELS(PIXELS)
   ) dut (
      .clk(clk), .rst(rst), .ss(ss), .spi_cycle_done(spi_cycle_done),
      .spi_byte_in(spi_byte_in), .spi_byte_out(spi_byte_out),
      .bram_addr(bram_addr), .bram_channel(bram_channel), .bram_we(bram_we),
      .bram_data_in(bram_data_in), .bram_data_out(bram_data_out),
      .pdi_active(pdi_active), .pdi_done(pdi_done), .busy(busy)
   );

   always #5 clk = ~clk;

   // BRAM with registered read, indexed by channel and address.
   logic [7:0] mem [0:3][0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (bram_we) mem[bram_channel][bram_addr] <= bram_data_in;
      bram_data_out <= mem[bram_channel][bram_addr];
   end

   typedef struct packed {
      logic [1:0]        ch;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_t;

   wr_t obs[$];
   wr_t expw[$];

   always @(negedge clk)
      if (rst && bram_we) obs.push_back('{bram_channel, bram_addr, bram_data_in});

   int total = 0;
   int bad   = 0;

   // Reference state
   logic       exp_err  = 1'b0;
   logic       exp_done = 1'b0;
   logic [7:0] exp_mem [0:NUM_CH-1][0:PIXELS-1];
   logic [7:0] wdata [0:PIXELS-1];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_status();
      return {6'b0, exp_done, exp_err};
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic raise_ss,
                            input logic early_pdi, output logic [7:0] seen);
      int g;
      g = $urandom_range(2, 4);
      @(posedge clk); #1;
      seen = spi_byte_out;
      spi_byte_in    = b;
      spi_cycle_done = 1'b1;
      if (raise_ss) ss = 1'b1;
      @(posedge clk); #1;
      spi_cycle_done = 1'b0;
      if (early_pdi) begin
         pdi_done = 1'b1;
         @(posedge clk); #1;
         pdi_done = 1'b0;
         repeat (g - 1) @(posedge clk);
      end else begin
         repeat (g) @(posedge clk);
      end
   endtask

   task automatic begin_frame();
      @(posedge clk); #1;
      ss = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic end_frame();
      int n;
      @(posedge clk); #1;
      ss = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("idle_busy", busy, 0);
      check_val("idle_pdi_active", pdi_active, 0);
      check_val("idle_status", spi_byte_out, exp_status());
      check_val("wr_count", obs.size(), expw.size());
      n = (obs.size() < expw.size()) ? obs.size() : expw.size();
      for (int i = 0; i < n; i++) check_val("wr_entry", obs[i], expw[i]);
      obs.delete();
      expw.delete();
   endtask

   // One command frame: cmd, then n data bytes (n < PIXELS means the frame is
   // cut short by ss, on the last byte itself when ss_sync is set).
   task automatic run_txn(input logic [7:0] cmd, input int n, input bit ss_sync,
                          input bit early_pdi, input int pdi_wait, input bit pdi_junk);
      logic [1:0] op, ch;
      logic [7:0] seen;
      op = cmd[7:6];
      ch = cmd[1:0];
      begin_frame();
      send_byte(cmd, 1'b0, early_pdi && op == 2'b11 && ch < NUM_CH, seen);
      check_val("pre_status", seen, exp_status());
      if (op == 2'b00) begin
         exp_err  = 1'b0;
         exp_done = 1'b0;
      end else if (int'(ch) >= NUM_CH) begin
         exp_err = 1'b1;
      end else if (op == 2'b01) begin
         for (int i = 0; i < n; i++) begin
            send_byte(wdata[i], ss_sync && (i == n - 1), 1'b0, seen);
            exp_mem[ch][i] = wdata[i];
            expw.push_back('{ch, ADDR_W'(i), wdata[i]});
         end
         if (n < PIXELS) exp_err = 1'b1;
      end else if (op == 2'b10) begin
         for (int i = 0; i < n; i++) begin
            send_byte(8'($urandom), 1'b0, 1'b0, seen);
            check_val("rd_data", seen, exp_mem[ch][i]);
         end
         if (n < PIXELS) exp_err = 1'b1;
      end else begin
         #1;
         check_val("pdi_busy", busy, 1);
         check_val("pdi_active_on", pdi_active, 1);
         if (pdi_junk) begin
            send_byte(8'h41, 1'b0, 1'b0, seen);
            #1;
            check_val("pdi_ignore_byte", busy, 1);
         end
         repeat (pdi_wait) @(posedge clk);
         #1;
         check_val("pdi_active_hold", pdi_active, 1);
         pdi_done = 1'b1;
         @(posedge clk); #1;
         pdi_done = 1'b0;
         check_val("pdi_active_off", pdi_active, 0);
         check_val("pdi_busy_off", busy, 0);
         exp_done = 1'b1;
      end
      end_frame();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seen;
      logic [1:0] op, ch;
      int n;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_spi_byte_out", spi_byte_out, 0);
      check_val("rst_bram_addr", bram_addr, 0);
      check_val("rst_bram_channel", bram_channel, 0);
      check_val("rst_bram_we", bram_we, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_pdi_active", pdi_active, 0);
      rst = 1'b1;

      // Fill all channels; channel 1 gets A0..A3
      for (int c = 0; c < NUM_CH; c++) begin
         for (int i = 0; i < PIXELS; i++)
            wdata[i] = (c == 1) ? 8'(8'hA0 + i) : 8'($urandom);
         run_txn({2'b01, 4'b0000, 2'(c)}, PIXELS, 1'b0, 1'b0, 0, 1'b0);
      end
      run_txn(8'h81, PIXELS, 1'b0, 1'b0, 0, 1'b0);
      run_txn(8'h43, 0, 1'b0, 1'b0, 0, 1'b0);
      check_val("bad_ch_status", spi_byte_out, 8'h01);
      run_txn(8'h00, 0, 1'b0, 1'b0, 0, 1'b0);
      check_val("nop_status", spi_byte_out, 8'h00);
      run_txn(8'hC0, 0, 1'b0, 1'b0, 10, 1'b0);
      check_val("pdi_status", spi_byte_out, 8'h02);
      for (int i = 0; i < PIXELS; i++) wdata[i] = 8'($urandom);
      run_txn(8'h42, 2, 1'b0, 1'b0, 0, 1'b0);
      run_txn(8'h40, 2, 1'b1, 1'b0, 0, 1'b0);
      run_txn(8'hC1, 0, 1'b0, 1'b1, 3, 1'b1);

      // Randomized frames
      for (int t = 0; t < 60; t++) begin
         op = 2'($urandom);
         ch = 2'($urandom);
         n  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PIXELS - 1) : PIXELS;
         for (int i = 0; i < PIXELS; i++) wdata[i] = 8'($urandom);
         run_txn({op, 4'($urandom), ch}, n, 1'($urandom), 1'($urandom),
                 $urandom_range(1, 10), 1'($urandom));
      end

      // Asynchronous reset in the middle of a read
      for (int i = 0; i < PIXELS; i++) wdata[i] = 8'(8'h51 + i);
      run_txn(8'h41, PIXELS, 1'b0, 1'b0, 0, 1'b0);
      begin_frame();
      send_byte(8'h81, 1'b0, 1'b0, seen);
      check_val("pre_rst_status", seen, exp_status());
      send_byte(8'h00, 1'b0, 1'b0, seen);
      check_val("pre_rst_rd", seen, exp_mem[1][0]);
      #3;
      rst = 1'b0;
      #1;
      check_val("arst_spi_byte_out", spi_byte_out, 0);
      check_val("arst_bram_addr", bram_addr, 0);
      check_val("arst_bram_channel", bram_channel, 0);
      check_val("arst_bram_we", bram_we, 0);
      check_val("arst_bram_data_in", bram_data_in, 0);
      check_val("arst_pdi_active", pdi_active, 0);
      check_val("arst_busy", busy, 0);
      @(posedge clk); #1;
      ss = 1'b1;
      rst = 1'b1;
      exp_err  = 1'b0;
      exp_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("post_rst_status", spi_byte_out, 8'h00);
      check_val("post_rst_writes", obs.size(), 0);
      for (int i = 0; i < PIXELS; i++) wdata[i] = 8'($urandom);
      run_txn(8'h42, PIXELS, 1'b0, 1'b0, 0, 1'b0);
      run_txn(8'h82, PIXELS, 1'b0, 1'b0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_transfer_ctrl.md
STREAM_TRANSFER_CTRL -- requirements
Module: stream_transfer_ctrl

Interface
REQ-001 Parameters (name, default, meaning), SHALL be: DATA_W, 8, SPI byte and BRAM word width; ADDR_W, 17, BRAM address width; NUM_CH, 3, number of image channels; PIXELS, 76800, words per channel frame (2..2^ADDR_W).
REQ-002 Ports (name direction width meaning), SHALL be: clk in 1 system clock; rst in 1 asynchronous active-low reset; ss in 1 SPI chip select, active-low; spi_cycle_done in 1 one-cycle pulse per received byte; spi_byte_in in DATA_W received byte; spi_byte_out out DATA_W byte for next SPI shift; bram_addr out ADDR_W BRAM address; bram_channel out 2 selected channel; bram_we out 1 BRAM write strobe; bram_data_in out DATA_W BRAM write data; bram_data_out in DATA_W BRAM read data; pdi_active out 1 image-processing enable; pdi_done in 1 image-processing complete; busy out 1 transfer/processing in progress.

Function
REQ-003 All state SHALL update on rising clk; reset is the only asynchronous path.
REQ-004 Command byte SHALL be decoded as opcode = spi_byte_in[DATA_W-1:DATA_W-2], channel = spi_byte_in[1:0]; opcodes: 00 NOP, 01 WRITE, 10 READ, 11 PROCESS.
REQ-005 FSM states SHALL be IDLE, WR, RD_PRE, RD, PDI; busy = 1 in every state except IDLE.
REQ-006 IDLE: spi_byte_out SHALL present status = {zeros, busy, done_flag, err} (bits 2..0), updated every cycle.
REQ-007 IDLE + spi_cycle_done: NOP clears err and done_flag; WRITE/READ/PROCESS with channel >= NUM_CH sets err=1, stays IDLE; otherwise latches bram_channel, clears word counter, goes WR / RD_PRE / PDI.
REQ-008 WR: each spi_cycle_done SHALL produce exactly one bram_we pulse in the same cycle, bram_data_in = spi_byte_in, bram_addr = counter; counter increments after; after write of word PIXELS-1 return to IDLE.
REQ-009 RD_PRE: bram_addr = counter for one cycle (1-cycle registered BRAM latency); next cycle spi_byte_out <= bram_data_out, go RD.
REQ-010 RD: spi_byte_out held stable; on spi_cycle_done, if counter == PIXELS-1 go IDLE, else counter++ and go RD_PRE. SPI byte period SHALL be >= 4 clk cycles.
REQ-011 PDI: pdi_active = 1 (registered, asserted the cycle after entry); on pdi_done = 1, pdi_active -> 0 next cycle, done_flag = 1, go IDLE. spi_cycle_done in PDI SHALL be ignored.
REQ-012 bram_we SHALL be 0 outside WR; bram_addr SHALL equal counter in all states; counter never exceeds PIXELS-1 (no wrap).
REQ-013 Abort: ss rising (1 sampled after 0) in WR, RD_PRE or RD SHALL return to IDLE next cycle, set err=1, no further bram_we; ss ignored in IDLE and PDI.
REQ-014 Simultaneous ss rising and spi_cycle_done in WR: the byte SHALL be written, then abort applies.
REQ-015 Simultaneous pdi_done and state entry into PDI: done SHALL be honoured only after pdi_active has been 1 for >= 1 cycle.

Reset
REQ-016 rst = 0 SHALL immediately force: state IDLE, counter 0, bram_addr 0, bram_channel 0, bram_we 0, bram_data_in 0, pdi_active 0, err 0, done_flag 0, busy 0, spi_byte_out 0.
REQ-017 Reset mid-WR/RD/PDI SHALL abandon the operation with no further bram_we; release to IDLE with clean status.

Verification (PIXELS = 4, NUM_CH = 3)
REQ-018 Write: bytes 0x41, 0xA0,0xA1,0xA2,0xA3 -> four bram_we pulses, addr 0..3, bram_channel = 1, data A0..A3, then IDLE, busy = 0.
REQ-019 Read: byte 0x81 with BRAM ch1 = A0..A3 -> spi_byte_out = A0, A1, A2, A3 valid before each next spi_cycle_done; ends IDLE.
REQ-020 Bad channel: byte 0x43 -> err = 1, status 0x01, no bram_we; then 0x00 -> status 0x00.
REQ-021 Process: byte 0xC0 -> busy = 1, pdi_active = 1; pulse pdi_done after 10 cycles -> pdi_active = 0, status 0x02.
REQ-022 Abort: 0x42, two data bytes, then ss high -> exactly 2 bram_we pulses, err = 1, IDLE.
REQ-023 Async reset: assert rst = 0 mid-RD without clk edge -> all outputs at REQ-016 values immediately.
